// File: rtl/popeye_dl_router.sv
// Download steering and core reset sequencing for the popeye core: routes ioctl ROM bytes to the
// core ROM port, latches DIP/mod bytes, and holds the core in reset until a valid ROM set loads.
module popeye_dl_router #(
  parameter logic [16:0] EXPECT_BYTES = 17'h18000,
  parameter int unsigned RST_STRETCH  = 64
) (
  input  logic        i_clk_sys,
  input  logic        i_reset,
  input  logic        i_user_reset,
  input  logic        i_ioctl_download,
  input  logic [7:0]  i_ioctl_index,
  input  logic        i_ioctl_wr,
  input  logic [24:0] i_ioctl_addr,
  input  logic [7:0]  i_ioctl_dout,
  output logic [16:0] o_dl_addr,
  output logic [7:0]  o_dl_data,
  output logic        o_dl_wr,
  output logic [7:0]  o_sw0,
  output logic [7:0]  o_sw1,
  output logic [7:0]  o_sw2,
  output logic        o_skyskipr,
  output logic        o_core_reset,
  output logic        o_rom_ok,
  output logic        o_rom_err,
  output logic        o_busy
);

  localparam int unsigned SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(RST_STRETCH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StError, StStretch, StRun} state_e;

  state_e        r_state, w_state_d;
  logic [SW-1:0] r_stretch, w_stretch_d;
  logic [17:0]   r_count;
  logic          r_overrun;
  logic          r_dl_prev;
  logic [16:0]   r_dl_addr;
  logic [7:0]    r_dl_data;
  logic          r_dl_wr;
  logic [7:0]    r_sw0, r_sw1, r_sw2;
  logic          r_skyskipr;
  logic          r_core_reset;
  logic          r_rom_ok, r_rom_err;
  logic          r_busy;

  logic w_is_rom, w_rom_start, w_rom_byte, w_in_range, w_rom_wr, w_rom_over;
  logic w_load_ok, w_load_err;

  assign w_is_rom = i_ioctl_download & (i_ioctl_index == 8'd0);
  // From IDLE only a fresh download edge counts, so a download cut by reset stays ignored.
  assign w_rom_start = w_is_rom & (r_state != StLoad) & ((r_state != StIdle) | ~r_dl_prev);
  assign w_rom_byte  = w_is_rom & i_ioctl_wr & (w_state_d == StLoad);
  assign w_in_range  = i_ioctl_addr < {8'd0, EXPECT_BYTES};
  assign w_rom_wr    = w_rom_byte & w_in_range;
  assign w_rom_over  = w_rom_byte & ~w_in_range;

  always_comb begin
    w_state_d   = r_state;
    w_stretch_d = r_stretch;
    w_load_ok   = 1'b0;
    w_load_err  = 1'b0;
    unique case (r_state)
      StIdle, StError: begin
        if (w_rom_start) w_state_d = StLoad;
      end
      StLoad: begin
        if (!i_ioctl_download) begin
          if (r_count == {1'b0, EXPECT_BYTES} && !r_overrun) begin
            w_load_ok   = 1'b1;
            w_state_d   = StStretch;
            w_stretch_d = STRETCH_LOAD;
          end else begin
            w_load_err = 1'b1;
            w_state_d  = StError;
          end
        end
      end
      StStretch: begin
        if (w_rom_start) begin
          w_state_d = StLoad;
        end else if (i_user_reset) begin
          w_stretch_d = STRETCH_LOAD;
        end else if (r_stretch == '0) begin
          w_state_d = StRun;
        end else begin
          w_stretch_d = r_stretch - 1'b1;
        end
      end
      StRun: begin
        if (w_rom_start) begin
          w_state_d = StLoad;
        end else if (i_user_reset) begin
          w_state_d   = StStretch;
          w_stretch_d = STRETCH_LOAD;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Tracks the raw download level even through reset so a held download is not seen as new.
  always_ff @(posedge i_clk_sys) begin
    r_dl_prev <= i_ioctl_download;
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_stretch    <= '0;
      r_busy       <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_stretch    <= w_stretch_d;
      r_busy       <= (w_state_d == StLoad);
      r_core_reset <= (w_state_d != StRun);
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_rom_ok  <= 1'b0;
      r_rom_err <= 1'b0;
      r_dl_wr   <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
    end else begin
      r_dl_wr <= w_rom_wr;
      if (w_rom_wr) begin
        r_dl_addr <= i_ioctl_addr[16:0];
        r_dl_data <= i_ioctl_dout;
      end
      if (w_rom_start) begin
        r_count   <= w_rom_wr ? 18'd1 : 18'd0;
        r_overrun <= w_rom_over;
        r_rom_ok  <= 1'b0;
        r_rom_err <= 1'b0;
      end else begin
        if (w_rom_wr && r_count != '1) r_count <= r_count + 18'd1;
        if (w_rom_over) r_overrun <= 1'b1;
        if (w_load_ok) r_rom_ok <= 1'b1;
        if (w_load_err) r_rom_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_sw0      <= 8'h00;
      r_sw1      <= 8'hC2;
      r_sw2      <= 8'h00;
      r_skyskipr <= 1'b0;
    end else begin
      if (i_ioctl_index == 8'd254 && i_ioctl_wr && i_ioctl_addr[24:3] == 22'd0) begin
        case (i_ioctl_addr[2:0])
          3'd0:    r_sw0 <= i_ioctl_dout;
          3'd1:    r_sw1 <= i_ioctl_dout;
          3'd2:    r_sw2 <= i_ioctl_dout;
          default: ;
        endcase
      end
      if (i_ioctl_index == 8'd1 && i_ioctl_wr) r_skyskipr <= |i_ioctl_dout;
    end
  end

  assign o_dl_addr    = r_dl_addr;
  assign o_dl_data    = r_dl_data;
  assign o_dl_wr      = r_dl_wr;
  assign o_sw0        = r_sw0;
  assign o_sw1        = r_sw1;
  assign o_sw2        = r_sw2;
  assign o_skyskipr   = r_skyskipr;
  assign o_core_reset = r_core_reset;
  assign o_rom_ok     = r_rom_ok;
  assign o_rom_err    = r_rom_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_popeye_dl_router.sv
// Bench for popeye_dl_router: phase-level model checked every cycle, plus literal spot checks.
// ROM size is scaled down so several full loads fit in a short run.
module tb_popeye_dl_router;

  localparam logic [16:0] EXP  = 17'h00600;
  localparam int          EXPN = 1536;
  localparam int          STR  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ureset = 1'b0;
  logic        dl = 1'b0;
  logic [7:0]  idx = 8'd0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = 8'd0;
  logic [16:0] dl_addr;
  logic [7:0]  dl_data, sw0, sw1, sw2;
  logic        dl_wr, sky, core_reset, rom_ok, rom_err, busy;

  popeye_dl_router #(.EXPECT_BYTES(EXP), .RST_STRETCH(STR)) dut (
    .i_clk_sys(clk), .i_reset(rst), .i_user_reset(ureset), .i_ioctl_download(dl),
    .i_ioctl_index(idx), .i_ioctl_wr(wr), .i_ioctl_addr(addr), .i_ioctl_dout(dout),
    .o_dl_addr(dl_addr), .o_dl_data(dl_data), .o_dl_wr(dl_wr), .o_sw0(sw0), .o_sw1(sw1),
    .o_sw2(sw2), .o_skyskipr(sky), .o_core_reset(core_reset), .o_rom_ok(rom_ok),
    .o_rom_err(rom_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_dlwr  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the download life cycle as named phases with a remaining-reset-cycles count.
  string       m_phase;
  int          m_bytes, m_left;
  bit          m_over, m_prev;
  logic        m_dl_wr, m_sky, m_ok, m_err;
  logic [16:0] m_addr;
  logic [7:0]  m_data, m_sw0, m_sw1, m_sw2;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = "idle"; m_bytes = 0; m_over = 0; m_left = 0;
      m_dl_wr = 0; m_addr = '0; m_data = '0;
      m_sw0 = 8'h00; m_sw1 = 8'hC2; m_sw2 = 8'h00; m_sky = 0; m_ok = 0; m_err = 0;
    end else begin
      m_dl_wr = 0;
      if (dl && idx == 0 && m_phase != "load" && (m_phase != "idle" || !m_prev)) begin
        m_phase = "load"; m_bytes = 0; m_over = 0; m_ok = 0; m_err = 0;
      end else if (m_phase == "load" && !dl) begin
        if (m_bytes == EXPN && !m_over) begin
          m_ok = 1; m_phase = "stretch"; m_left = STR;
        end else begin
          m_err = 1; m_phase = "error";
        end
      end else if ((m_phase == "run" || m_phase == "stretch") && ureset) begin
        m_phase = "stretch"; m_left = STR;
      end else if (m_phase == "stretch") begin
        m_left--;
        if (m_left == 0) m_phase = "run";
      end
      if (m_phase == "load" && dl && idx == 0 && wr) begin
        if (addr < EXPN) begin
          m_dl_wr = 1; m_addr = addr[16:0]; m_data = dout;
          if (m_bytes < 262143) m_bytes++;
        end else begin
          m_over = 1;
        end
      end
      if (idx == 8'd254 && wr && addr < 8) begin
        if (addr == 0) m_sw0 = dout;
        if (addr == 1) m_sw1 = dout;
        if (addr == 2) m_sw2 = dout;
      end
      if (idx == 8'd1 && wr) m_sky = |dout;
    end
    m_prev = dl;
  end

  logic [54:0] act_vec, exp_vec;
  assign act_vec = {dl_wr, dl_addr, dl_data, sw0, sw1, sw2, sky, core_reset, rom_ok, rom_err,
                    busy};
  always_comb begin
    exp_vec = {m_dl_wr, m_addr, m_data, m_sw0, m_sw1, m_sw2, m_sky,
               (m_phase != "run") ? 1'b1 : 1'b0, m_ok, m_err,
               (m_phase == "load") ? 1'b1 : 1'b0};
  end

  always @(negedge clk) begin
    if (chk_en) check("outputs", 64'(act_vec), 64'(exp_vec));
    if (dl_wr === 1'b1) n_dlwr++;
  end

  task automatic rom_load(input int nbytes, input int rst_at, input bit extra);
    @(negedge clk); idx = 8'd0; dl = 1'b1; wr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      addr = 25'(i); dout = 8'(i * 7 + 3); wr = 1'b1;
      if (i == rst_at) rst = 1'b1;
      @(negedge clk); wr = 1'b0; rst = 1'b0;
      if (i % 8 == 5) @(negedge clk);
    end
    if (extra) begin
      addr = 25'h000600; dout = 8'hEE; wr = 1'b1;
      @(negedge clk);
      addr = 25'h020000; dout = 8'hDD;
      @(negedge clk); wr = 1'b0;
    end
    @(negedge clk); dl = 1'b0;
  endtask

  task automatic put(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk); idx = ix; addr = a; dout = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  // Counts cycles core_reset stays high after the edge that sees download low (64 expected).
  task automatic load_release(output int held);
    @(posedge clk);
    held = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!core_reset) break;
      held++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_sw1", 64'(sw1), 64'h C2);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_flags", 64'({rom_ok, rom_err, busy, dl_wr}), 64'd0);
    repeat (3) @(negedge clk);

    // T1 exact load
    n_dlwr = 0;
    rom_load(EXPN, -1, 1'b0);
    load_release(held);
    check("t1_release", 64'(held), 64'd64);
    check("t1_dlwr_count", 64'(n_dlwr), 64'(EXPN));
    check("t1_flags", 64'({rom_ok, rom_err, core_reset}), 64'b100);

    // T4 DIP/mod in RUN
    @(negedge clk); idx = 8'd254; dl = 1'b1;
    put(8'd254, 25'd0, 8'h0F);
    put(8'd254, 25'd1, 8'h42);
    put(8'd254, 25'd2, 8'h01);
    put(8'd254, 25'd3, 8'hFF);
    put(8'd254, 25'd8, 8'hAA);
    @(negedge clk); dl = 1'b0;
    @(negedge clk); idx = 8'd1; dl = 1'b1;
    put(8'd1, 25'd0, 8'h01);
    @(negedge clk); dl = 1'b0; idx = 8'd0;
    @(negedge clk);
    check("t4_sw", 64'({sw0, sw1, sw2}), 64'h0F4201);
    check("t4_sky", 64'(sky), 64'd1);
    check("t4_core_reset", 64'(core_reset), 64'd0);

    // T5 user reset in RUN, held 10 cycles
    @(negedge clk); ureset = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_core_reset_high", 64'(core_reset), 64'd1);
    ureset = 1'b0;
    held = 1;  // the last edge that saw the request re-arms a full stretch
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!core_reset) break;
      held++;
    end
    check("t5_release", 64'(held), 64'd64);

    // T2 short load, user reset ignored in error, then full reload
    n_dlwr = 0;
    rom_load(1000, -1, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_short_flags", 64'({rom_ok, rom_err, core_reset}), 64'b011);
    check("t2_dlwr_count", 64'(n_dlwr), 64'd1000);
    ureset = 1'b1; repeat (3) @(negedge clk); ureset = 1'b0;
    repeat (80) @(negedge clk);
    check("t2_error_hold", 64'(core_reset), 64'd1);
    rom_load(EXPN, -1, 1'b0);
    repeat (70) @(negedge clk);
    check("t2_reload_flags", 64'({rom_ok, rom_err, core_reset}), 64'b100);

    // T3 overrun inside a full load
    n_dlwr = 0;
    rom_load(EXPN, -1, 1'b1);
    repeat (70) @(negedge clk);
    check("t3_dlwr_count", 64'(n_dlwr), 64'(EXPN));
    check("t3_flags", 64'({rom_ok, rom_err, core_reset}), 64'b011);

    // T6 reset at byte 500; the rest of that download must be ignored
    n_dlwr = 0;
    rom_load(1000, 500, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_dlwr_count", 64'(n_dlwr), 64'd500);
    check("t6_sw", 64'({sw0, sw1, sw2, sky}), 64'({8'h00, 8'hC2, 8'h00, 1'b0}));
    check("t6_flags", 64'({rom_ok, rom_err, core_reset, busy}), 64'b0010);

    // Fresh download after reset still loads
    rom_load(EXPN, -1, 1'b0);
    load_release(held);
    check("t7_release", 64'(held), 64'd64);
    check("t7_flags", 64'({rom_ok, rom_err}), 64'b10);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
